fp16_mul_driver: RTL

- Initiator end of the stb/ack operand-and-result protocol used by the 16-bit FPU datapaths; drives one fp16 multiplier instance.
- Accepts operand pairs on a valid/ready stream and presents them to the multiplier's input_a/input_b ack-only inputs.
- Collects output_z via stb/ack into a result FIFO.
- Holds the multiplier in reset while idle so it never consumes operands that were not issued, and guards against a hung unit with a watchdog.

---
 rtl/fp16_pkg.sv | 23 ++
 rtl/fp16_mul_driver_if.sv | 42 ++++
 rtl/fp16_res_fifo.sv | 64 ++++++
 rtl/fp16_mul_driver.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fp16_pkg
// Desc     : Shared widths, fp16 constants and driver state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package fp16_pkg;

    localparam int FP16_W = 16;

    localparam logic [FP16_W-1:0] FP16_QNAN = 16'hFE00;
    localparam logic [FP16_W-1:0] FP16_PINF = 16'h7C00;
    localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED_A = 2'd1,
        FEED_B = 2'd2,
        WAIT_Z = 2'd3
    } drv_state_t;

endpackage
`default_nettype wire

// File: rtl/fp16_mul_driver_if.sv
`default_nettype none
// ============================================================================
// Interface : fp16_mul_driver_if
// Desc      : Operand stream, result stream and multiplier-side stb/ack bus.
// Revision  : 1.0 - initial release
// ============================================================================
interface fp16_mul_driver_if;
    import fp16_pkg::*;

    logic              op_valid;
    logic              op_ready;
    logic [FP16_W-1:0] op_a;
    logic [FP16_W-1:0] op_b;
    logic              res_valid;
    logic              res_ready;
    logic [FP16_W-1:0] res_data;
    logic              fpu_rst;
    logic [FP16_W-1:0] fpu_a;
    logic [FP16_W-1:0] fpu_b;
    logic              fpu_a_ack;
    logic              fpu_b_ack;
    logic [FP16_W-1:0] fpu_z;
    logic              fpu_z_stb;
    logic              fpu_z_ack;

    // slave is the driver's view; master is the surrounding system + multiplier
    modport slave (
        input  op_valid, op_a, op_b, res_ready,
        input  fpu_a_ack, fpu_b_ack, fpu_z, fpu_z_stb,
        output op_ready, res_valid, res_data,
        output fpu_rst, fpu_a, fpu_b, fpu_z_ack
    );

    modport master (
        output op_valid, op_a, op_b, res_ready,
        output fpu_a_ack, fpu_b_ack, fpu_z, fpu_z_stb,
        input  op_ready, res_valid, res_data,
        input  fpu_rst, fpu_a, fpu_b, fpu_z_ack
    );

endinterface
`default_nettype wire

// File: rtl/fp16_res_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fp16_res_fifo
// Desc     : Show-ahead result FIFO; head reads as zero while empty.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  wire                     clk,
    input  wire                     rst,
    input  wire                     push,
    input  wire  [WIDTH-1:0]        push_data,
    input  wire                     pop,
    output logic [WIDTH-1:0]        head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int                c_AW      = $clog2(DEPTH);
    localparam logic [c_AW-1:0]   c_PTR_ONE = (c_AW)'(1);
    localparam logic [c_AW:0]     c_CNT_ONE = (c_AW+1)'(1);
    localparam logic [c_AW:0]     c_CNT_MAX = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // A full FIFO refuses the write even when a pop frees a slot this cycle
    assign w_push    = push & ~full;
    assign w_pop     = pop & ~empty;
    assign full      = (r_count == c_CNT_MAX);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_mul_driver.sv
`default_nettype none
// ============================================================================
// Module   : fp16_mul_driver
// Desc     : Feeds one fp16 multiplier over stb/ack, buffers its results and
//            aborts hung operations with a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_mul_driver
    import fp16_pkg::*;
#(
    parameter int RES_DEPTH = 4,
    parameter int TIMEOUT   = 64
) (
    input  wire                   clk,
    input  wire                   rst,
    fp16_mul_driver_if.slave      bus,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [15:0]           op_count
);

    localparam int                c_WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [c_WD_W-1:0] c_WD_ONE  = (c_WD_W)'(1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = (c_WD_W)'(TIMEOUT - 1);

    drv_state_t          r_state;
    logic                r_fpu_rst_q;
    logic [FP16_W-1:0]   r_fpu_a;
    logic [FP16_W-1:0]   r_fpu_b;
    logic                r_pend_valid;
    logic [FP16_W-1:0]   r_pend_a;
    logic [FP16_W-1:0]   r_pend_b;
    logic [c_WD_W-1:0]   r_wdog;
    logic                r_timeout_err;
    logic [15:0]         r_op_count;

    logic                w_op_fire;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_z_ack;
    logic                w_push;
    logic                w_pop;
    logic                w_wd_tick;
    logic                w_wd_expire;
    logic [$clog2(RES_DEPTH):0] w_unused_fifo_count;

    assign w_op_fire   = bus.op_valid & ~r_pend_valid;
    assign w_z_ack     = (r_state == WAIT_Z) & ~w_fifo_full;
    assign w_push      = bus.fpu_z_stb & w_z_ack;
    assign w_pop       = bus.res_ready & ~w_fifo_empty;
    // A full FIFO is downstream stall, not a hung multiplier
    assign w_wd_tick   = (r_state != IDLE) & ~((r_state == WAIT_Z) & w_fifo_full);
    assign w_wd_expire = w_wd_tick & (r_wdog == c_WD_LAST);

    assign bus.op_ready  = ~r_pend_valid;
    assign bus.res_valid = ~w_fifo_empty;
    assign bus.fpu_rst   = rst | r_fpu_rst_q;
    assign bus.fpu_a     = r_fpu_a;
    assign bus.fpu_b     = r_fpu_b;
    assign bus.fpu_z_ack = w_z_ack;
    assign busy          = (r_state != IDLE);
    assign timeout_err   = r_timeout_err;
    assign op_count      = r_op_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_fpu_rst_q   <= 1'b1;
            r_fpu_a       <= '0;
            r_fpu_b       <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_a      <= '0;
            r_pend_b      <= '0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
            r_op_count    <= '0;
        end else begin
            if (w_op_fire) begin
                r_pend_a     <= bus.op_a;
                r_pend_b     <= bus.op_b;
                r_pend_valid <= 1'b1;
            end
            if (w_wd_tick) begin
                r_wdog <= r_wdog + c_WD_ONE;
            end
            if (w_push) begin
                r_op_count <= r_op_count + 16'd1;
            end

            case (r_state)
                IDLE: begin
                    r_fpu_rst_q <= 1'b1;
                    if (r_pend_valid) begin
                        r_fpu_a      <= r_pend_a;
                        r_fpu_b      <= r_pend_b;
                        r_pend_valid <= 1'b0;
                        r_fpu_rst_q  <= 1'b0;
                        r_wdog       <= '0;
                        r_state      <= FEED_A;
                    end
                end
                FEED_A: begin
                    if (w_wd_expire) begin
                        r_timeout_err <= 1'b1;
                        r_fpu_rst_q   <= 1'b1;
                        r_state       <= IDLE;
                    end else if (bus.fpu_a_ack) begin
                        r_state <= FEED_B;
                    end
                end
                FEED_B: begin
                    if (w_wd_expire) begin
                        r_timeout_err <= 1'b1;
                        r_fpu_rst_q   <= 1'b1;
                        r_state       <= IDLE;
                    end else if (bus.fpu_b_ack) begin
                        r_state <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (w_push) begin
                        if (r_pend_valid) begin
                            // Back-to-back: multiplier is already back in get_a
                            r_fpu_a      <= r_pend_a;
                            r_fpu_b      <= r_pend_b;
                            r_pend_valid <= 1'b0;
                            r_wdog       <= '0;
                            r_state      <= FEED_A;
                        end else begin
                            r_fpu_rst_q <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end else if (w_wd_expire) begin
                        r_timeout_err <= 1'b1;
                        r_fpu_rst_q   <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_fpu_rst_q <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    fp16_res_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (FP16_W)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (bus.fpu_z),
        .pop       (w_pop),
        .head_data (bus.res_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_unused_fifo_count)
    );

endmodule
`default_nettype wire
